// File: rtl/instr_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction queue.
// The slave modport is the queue side; the master modport is the fetch/decode side.
interface instr_queue_if #(
  parameter int DBITS    = 32,
  parameter int PTR_BITS = 2
);
  logic                enqValid;
  logic [DBITS-1:0]    enqPc;
  logic [DBITS-1:0]    enqInstr;
  logic                enqReady;
  logic                deqValid;
  logic [DBITS-1:0]    deqPc;
  logic [DBITS-1:0]    deqInstr;
  logic                deqReady;
  logic                flush;
  logic [PTR_BITS:0]   count;

  modport slave (
    input  enqValid, enqPc, enqInstr, deqReady, flush,
    output enqReady, deqValid, deqPc, deqInstr, count
  );

  modport master (
    output enqValid, enqPc, enqInstr, deqReady, flush,
    input  enqReady, deqValid, deqPc, deqInstr, count
  );
endinterface

// File: rtl/instr_queue.sv
// Circular FIFO of {pc, instr} pairs between fetch and decode.
// A redirect flush empties the queue; reset also clears the storage.
module instr_queue #(
  parameter int DBITS    = 32,
  parameter int DEPTH    = 4,
  parameter int PTR_BITS = 2
) (
  input  logic          clk,
  input  logic          res,
  instr_queue_if.slave  q
);

  logic [2*DBITS-1:0] storage_q [DEPTH];
  logic [2*DBITS-1:0] storage_d [DEPTH];
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS:0]   count_q, count_d;

  logic enq_ready, deq_valid, enq_fire, deq_fire;

  // Handshake readiness comes from registered occupancy only.
  assign enq_ready = (count_q != (PTR_BITS+1)'(DEPTH));
  assign deq_valid = (count_q != '0);
  assign enq_fire  = q.enqValid && enq_ready;
  assign deq_fire  = deq_valid && q.deqReady;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    storage_d = storage_q;
    if (q.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) begin
        storage_d[wr_ptr_q] = {q.enqPc, q.enqInstr};
        wr_ptr_d            = wr_ptr_q + PTR_BITS'(1);
      end
      if (deq_fire) begin
        rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
      end
      if (enq_fire && !deq_fire) begin
        count_d = count_q + (PTR_BITS+1)'(1);
      end else if (deq_fire && !enq_fire) begin
        count_d = count_q - (PTR_BITS+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      storage_q <= '{default: '0};
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      storage_q <= storage_d;
    end
  end

  assign q.enqReady = enq_ready;
  assign q.deqValid = deq_valid;
  assign q.deqPc    = storage_q[rd_ptr_q][2*DBITS-1:DBITS];
  assign q.deqInstr = storage_q[rd_ptr_q][DBITS-1:0];
  assign q.count    = count_q;

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations at each test step.
module tb_instr_queue;
  localparam int DBITS = 32;
  localparam int DEPTH = 4;
  localparam int PB    = 2;

  logic clk = 1'b0;
  logic res;
  instr_queue_if #(.DBITS(DBITS), .PTR_BITS(PB)) bus ();

  instr_queue #(.DBITS(DBITS), .DEPTH(DEPTH), .PTR_BITS(PB)) dut (
    .clk (clk),
    .res (res),
    .q   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: an ordered list of queued {pc, instr} pairs.
  logic [63:0] mq[$];
  bit known     = 0;
  bit after_rst = 0;

  always @(posedge clk) begin
    bit e, d;
    if (res) begin
      mq.delete();
      after_rst = 1;
      known     = 1;
    end else if (known) begin
      if (bus.flush) begin
        mq.delete();
        after_rst = 0;
      end else begin
        e = bus.enqValid && (mq.size() < DEPTH);
        d = bus.deqReady && (mq.size() > 0);
        if (d) void'(mq.pop_front());
        if (e) begin
          mq.push_back({bus.enqPc, bus.enqInstr});
          after_rst = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (known) begin
      chk("model_count", 64'(bus.count), 64'(mq.size()));
      chk("model_enqReady", 64'(bus.enqReady), 64'(mq.size() != DEPTH));
      chk("model_deqValid", 64'(bus.deqValid), 64'(mq.size() != 0));
      if (mq.size() > 0)
        chk("model_head", {bus.deqPc, bus.deqInstr}, mq[0]);
      else if (after_rst)
        chk("model_reset_head", {bus.deqPc, bus.deqInstr}, 64'd0);
    end
  end

  task automatic step(input logic ev, input logic [31:0] pc, input logic [31:0] ins,
                      input logic dr, input logic fl, input logic rs);
    bus.enqValid = ev;
    bus.enqPc    = pc;
    bus.enqInstr = ins;
    bus.deqReady = dr;
    bus.flush    = fl;
    res          = rs;
    @(posedge clk);
    #1;
    $display("t=%0t enq=%0b pc=%h ins=%h deqRdy=%0b flush=%0b res=%0b -> count=%0d deqV=%0b deqPc=%h",
             $time, ev, pc, ins, dr, fl, rs, bus.count, bus.deqValid, bus.deqPc);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1'b1;
    bus.enqValid = 0; bus.enqPc = '0; bus.enqInstr = '0;
    bus.deqReady = 0; bus.flush = 0;

    // 1. reset then idle
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_deqValid", 64'(bus.deqValid), 64'd0);
    chk("rst_enqReady", 64'(bus.enqReady), 64'd1);
    chk("rst_deqPc", 64'(bus.deqPc), 64'd0);
    chk("rst_deqInstr", 64'(bus.deqInstr), 64'd0);
    step(0, 0, 0, 0, 0, 0);

    // 2. fill without dequeue
    for (int k = 0; k < 4; k++) begin
      step(1, 32'h40 + 32'(4*k), 32'hA0 + 32'(k), 0, 0, 0);
      chk("fill_count", 64'(bus.count), 64'(k + 1));
    end
    chk("full_enqReady", 64'(bus.enqReady), 64'd0);
    step(1, 32'h50, 32'hA4, 0, 0, 0);
    chk("full_reject_count", 64'(bus.count), 64'd4);
    chk("full_head_pc", 64'(bus.deqPc), 64'h40);

    // 3. drain order
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc", 64'(bus.deqPc), 64'h40 + 64'(4*k));
      chk("drain_instr", 64'(bus.deqInstr), 64'hA0 + 64'(k));
      step(0, 0, 0, 1, 0, 0);
    end
    chk("drain_deqValid", 64'(bus.deqValid), 64'd0);
    chk("drain_count", 64'(bus.count), 64'd0);

    // 4. steady streaming with pointer wrap
    for (int k = 0; k < 10; k++) begin
      step(1, 32'h40 + 32'(4*k), 32'hB0 + 32'(k), 1, 0, 0);
      chk("stream_count", 64'(bus.count), 64'd1);
      chk("stream_pc", 64'(bus.deqPc), 64'h40 + 64'(4*k));
    end
    step(0, 0, 0, 1, 0, 0);
    chk("stream_end_count", 64'(bus.count), 64'd0);

    // 5. flush with traffic
    for (int k = 0; k < 3; k++) step(1, 32'h60 + 32'(4*k), 32'hC0 + 32'(k), 0, 0, 0);
    chk("preflush_count", 64'(bus.count), 64'd3);
    step(1, 32'h80, 32'hD0, 1, 1, 0);
    chk("flush_count", 64'(bus.count), 64'd0);
    chk("flush_deqValid", 64'(bus.deqValid), 64'd0);
    chk("flush_enqReady", 64'(bus.enqReady), 64'd1);
    step(1, 32'h84, 32'hD1, 0, 0, 0);
    chk("postflush_deqValid", 64'(bus.deqValid), 64'd1);
    chk("postflush_pc", 64'(bus.deqPc), 64'h84);
    chk("postflush_instr", 64'(bus.deqInstr), 64'hD1);
    step(0, 0, 0, 1, 0, 0);
    chk("postflush_empty", 64'(bus.count), 64'd0);

    // 6. reset mid-operation with a full queue
    for (int k = 0; k < 4; k++) step(1, 32'h100 + 32'(4*k), 32'hE0 + 32'(k), 0, 0, 0);
    chk("prereset_count", 64'(bus.count), 64'd4);
    step(1, 32'h200, 32'hF0, 1, 1, 1);
    chk("midrst_count", 64'(bus.count), 64'd0);
    chk("midrst_enqReady", 64'(bus.enqReady), 64'd1);
    chk("midrst_deqValid", 64'(bus.deqValid), 64'd0);
    chk("midrst_deqPc", 64'(bus.deqPc), 64'd0);
    chk("midrst_deqInstr", 64'(bus.deqInstr), 64'd0);
    step(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
Fetch-to-decode instruction queue. It sits directly downstream of the fetch stage and buffers up to DEPTH fetched {pc, instr} pairs in FIFO order. It decouples fetch from decode stalls and discards all queued entries on a redirect flush (taken branch or jump).

Parameters:
DBITS, 32, width of PC and instruction words
DEPTH, 4, queue entries; power of two, minimum 2
PTR_BITS, 2, log2(DEPTH); index width

Ports:
clk  in  1  clock; all state updates on rising edge
res  in  1  synchronous active-high reset
enqValid  in  1  fetch presents a valid entry
enqPc  in  DBITS  PC of the fetched instruction
enqInstr  in  DBITS  fetched instruction word
enqReady  out  1  queue can accept an entry this cycle
deqValid  out  1  head entry is valid
deqPc  out  DBITS  PC of the head entry
deqInstr  out  DBITS  instruction word of the head entry
deqReady  in  1  decode consumes the head this cycle
flush  in  1  discard all entries (redirect)
count  out  PTR_BITS+1  number of occupied entries, 0..DEPTH

Behaviour:
- State: storage array DEPTH x (2*DBITS), rdPtr and wrPtr (PTR_BITS each, wrap modulo DEPTH), count register (PTR_BITS+1 bits).
- Enqueue fires when enqValid && enqReady. Write {enqPc, enqInstr} at wrPtr; wrPtr+1.
- Dequeue fires when deqValid && deqReady. rdPtr+1.
- enqReady = (count != DEPTH). It depends on registered state only; no combinational path from deqReady.
- deqValid = (count != 0).
- deqPc/deqInstr = storage[rdPtr]. When deqValid=0 the values are don't-care, except after reset, when they are 0.
- count next value: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
- Latency: an entry enqueued in cycle N is visible at deq in cycle N+1. There is no same-cycle bypass when empty.
- Full: enqReady=0; enqValid is ignored even if a dequeue fires in the same cycle. enqReady rises the cycle after the dequeue.
- Empty: deqValid=0; deqReady is ignored and rdPtr does not move.
- Simultaneous enqueue and dequeue (0<count<DEPTH): both pointers advance and count is unchanged.
- Pointer wrap: DEPTH-1 -> 0, with no lost or duplicated entries.
- flush=1 at an edge: rdPtr=wrPtr=0 and count=0.
  - Any enqueue or dequeue in that cycle is discarded; no pointer or count side-effects remain.
  - Next cycle: deqValid=0, enqReady=1.
  - Storage contents need not be cleared.
- res=1 at an edge: same as flush, and the storage is also cleared to 0.
  - Reset outputs: deqValid=0, enqReady=1, count=0, deqPc=0, deqInstr=0.
  - res overrides flush and all handshakes, including mid-stream with a full queue.
- No X propagation from storage: all storage is written or reset before it is read as valid.

Test Plan:
1. Reset then idle: assert res 2 cycles -> count=0, deqValid=0, enqReady=1, deqPc=0, deqInstr=0.
2. Fill with deqReady=0:
   - Stimulus: enqueue pc 0x40,0x44,0x48,0x4C with instr 0xA0..0xA3.
   - Required: count steps 1,2,3,4; enqReady=0 after the 4th.
   - Required: a 5th enqValid (pc 0x50) is not accepted and count stays 4.
3. Drain order: from test 2, hold deqReady=1.
   - Required: deq sequence is (0x40,0xA0),(0x44,0xA1),(0x48,0xA2),(0x4C,0xA3).
   - Required: then deqValid=0 and count=0.
4. Steady streaming with wrap:
   - Stimulus: enqValid=1 and deqReady=1 every cycle for 10 cycles with pc 0x40+4k.
   - Required: each pc emerges exactly once, in order, one cycle after it was enqueued.
   - Required: count holds at 1 after the first cycle; pointers wrap past 3 correctly.
5. Flush with traffic:
   - Stimulus: with count=3, assert flush together with enqValid (pc 0x80) and deqReady.
   - Required: next cycle count=0, deqValid=0, and pc 0x80 is never dequeued.
   - Required: a following enqueue of pc 0x84 appears at deq the next cycle.
6. Reset mid-operation: with the queue full, assert res together with flush and deqReady -> next cycle count=0, enqReady=1, deqValid=0, deqPc=0.
